// File: rtl/mc14433_bcd_rx.sv
// mc14433_bcd_rx
//   Receives the multiplexed BCD output of an MC14433 3.5-digit ADC. It
//   reassembles one conversion frame and publishes it as latched BCD plus an
//   11-bit binary magnitude.
// Ports
//   CP15            clock, rising edge
//   R               synchronous reset, active low
//   DS1..DS4        digit strobes (DS1 = MSD/flags, DS4 = units)
//   Q[3:0]          multiplexed data, valid while its strobe is high
//   MSD,D2,D3,D4    latched half digit and BCD digits
//   POL,OVR,UNR     polarity (1 = positive), overrange, underrange
//   BIN[10:0]       MSD*1000 + D2*100 + D3*10 + D4
//   VALID           one-cycle pulse when the outputs update
//   FERR            one-cycle pulse on a malformed or timed-out frame
module mc14433_bcd_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int TMO         = 4096
) (
  input  logic        CP15,
  input  logic        R,
  input  logic        DS1,
  input  logic        DS2,
  input  logic        DS3,
  input  logic        DS4,
  input  logic [3:0]  Q,
  output logic        MSD,
  output logic [3:0]  D2,
  output logic [3:0]  D3,
  output logic [3:0]  D4,
  output logic        POL,
  output logic        OVR,
  output logic        UNR,
  output logic [10:0] BIN,
  output logic        VALID,
  output logic        FERR
);

  localparam int CW = (TMO > 2) ? $clog2(TMO) : 1;
  // The counter is compared one short of TMO-1: the error is flagged on the
  // edge at which the count would reach TMO-1.
  localparam logic [CW-1:0] TLIM = CW'(TMO - 2);

  typedef enum logic [1:0] {IDLE, WAIT2, WAIT3, WAIT4} state_t;

  state_t                        state;
  logic [SYNC_STAGES-1:0][3:0]   ds_sync, q_sync;
  logic [3:0]                    ds_prev;
  logic [CW-1:0]                 cnt;
  logic                          sh_msd, sh_pol, sh_ovr, sh_unr;
  logic [3:0]                    sh_d2, sh_d3;

  logic [3:0]  ds_s, q_s, edges, exp_edge;
  logic        multi;
  logic [10:0] bin_next;

  assign ds_s  = ds_sync[SYNC_STAGES-1];
  assign q_s   = q_sync[SYNC_STAGES-1];
  assign edges = ds_s & ~ds_prev;
  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi = (edges & (edges - 4'd1)) != 4'd0;

  // Incoming D4 is added directly so BIN lands with the BCD outputs.
  assign bin_next = (sh_msd ? 11'd1000 : 11'd0) + 11'(sh_d2) * 11'd100
                  + 11'(sh_d3) * 11'd10 + 11'(q_s);

  always_comb begin
    exp_edge = 4'b0000;
    case (state)
      WAIT2:   exp_edge = 4'b0010;
      WAIT3:   exp_edge = 4'b0100;
      WAIT4:   exp_edge = 4'b1000;
      default: exp_edge = 4'b0000;
    endcase
  end

  always_ff @(posedge CP15) begin
    if (!R) begin
      state   <= IDLE;
      ds_sync <= '0;
      q_sync  <= '0;
      ds_prev <= '0;
      cnt     <= '0;
      sh_msd  <= 1'b0;
      sh_pol  <= 1'b0;
      sh_ovr  <= 1'b0;
      sh_unr  <= 1'b0;
      sh_d2   <= '0;
      sh_d3   <= '0;
      MSD     <= 1'b0;
      D2      <= '0;
      D3      <= '0;
      D4      <= '0;
      POL     <= 1'b0;
      OVR     <= 1'b0;
      UNR     <= 1'b0;
      BIN     <= '0;
      VALID   <= 1'b0;
      FERR    <= 1'b0;
    end else begin
      for (int i = SYNC_STAGES - 1; i > 0; i--) begin
        ds_sync[i] <= ds_sync[i-1];
        q_sync[i]  <= q_sync[i-1];
      end
      ds_sync[0] <= {DS4, DS3, DS2, DS1};
      q_sync[0]  <= Q;
      ds_prev    <= ds_s;
      VALID      <= 1'b0;
      FERR       <= 1'b0;

      if (multi && (state != IDLE || edges[0])) begin
        FERR  <= 1'b1;
        state <= IDLE;
        cnt   <= '0;
      end else if (edges[0]) begin
        // DS1 always (re)starts a frame; mid-frame it also aborts the old one.
        if (state != IDLE) FERR <= 1'b1;
        sh_msd <= ~q_s[3];
        sh_pol <= q_s[2];
        sh_ovr <= q_s[0] & ~q_s[3];
        sh_unr <= q_s[0] & q_s[3];
        state  <= WAIT2;
        cnt    <= '0;
      end else if (state == IDLE) begin
        // Stray DS2..DS4 edges while idle: joined mid-frame, wait for DS1.
        cnt <= '0;
      end else if (edges != 4'd0) begin
        cnt <= '0;
        if (edges != exp_edge || q_s > 4'd9) begin
          FERR  <= 1'b1;
          state <= IDLE;
        end else begin
          case (state)
            WAIT2: begin
              sh_d2 <= q_s;
              state <= WAIT3;
            end
            WAIT3: begin
              sh_d3 <= q_s;
              state <= WAIT4;
            end
            default: begin
              MSD   <= sh_msd;
              D2    <= sh_d2;
              D3    <= sh_d3;
              D4    <= q_s;
              POL   <= sh_pol;
              OVR   <= sh_ovr;
              UNR   <= sh_unr;
              BIN   <= bin_next;
              VALID <= 1'b1;
              state <= IDLE;
            end
          endcase
        end
      end else if (cnt == TLIM) begin
        FERR  <= 1'b1;
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mc14433_bcd_rx.sv
// tb_mc14433_bcd_rx
//   Directed frames with hand-computed results. Stimulus pushes the expected
//   VALID/FERR event (kind, output bundle, arrival cycle) into a queue; a
//   monitor on the falling edge pops one entry per VALID or FERR pulse.
module tb_mc14433_bcd_rx;
  localparam int SS = 2;
  localparam int TM = 16;

  logic        CP15 = 1'b0;
  logic        R = 1'b0;
  logic        DS1 = 1'b0, DS2 = 1'b0, DS3 = 1'b0, DS4 = 1'b0;
  logic [3:0]  Q = 4'd0;
  logic        MSD, POL, OVR, UNR, VALID, FERR;
  logic [3:0]  D2, D3, D4;
  logic [10:0] BIN;

  mc14433_bcd_rx #(.SYNC_STAGES(SS), .TMO(TM)) dut (
    .CP15(CP15), .R(R), .DS1(DS1), .DS2(DS2), .DS3(DS3), .DS4(DS4), .Q(Q),
    .MSD(MSD), .D2(D2), .D3(D3), .D4(D4), .POL(POL), .OVR(OVR), .UNR(UNR),
    .BIN(BIN), .VALID(VALID), .FERR(FERR)
  );

  always #5 CP15 = ~CP15;

  int cyc = 0;
  always @(posedge CP15) cyc <= cyc + 1;

  typedef struct {
    bit          is_valid;
    int          at;
    logic [26:0] outs;
  } exp_t;

  exp_t        sb[$];
  logic [26:0] held = '0;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [26:0] mk(input logic m, input logic [3:0] a,
      input logic [3:0] b, input logic [3:0] c, input logic p,
      input logic o, input logic u, input logic [10:0] bn);
    return {m, a, b, c, p, o, u, bn};
  endfunction

  function automatic logic [26:0] cur();
    return {MSD, D2, D3, D4, POL, OVR, UNR, BIN};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Monitor: one queue entry per output event.
  always @(negedge CP15) begin
    if (VALID || FERR) begin
      chk("valid_ferr_exclusive", {31'd0, VALID & FERR}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_event", {30'd0, VALID, FERR}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("event_kind", {31'd0, VALID}, {31'd0, e.is_valid});
        chk("outputs", {5'd0, cur()}, {5'd0, e.outs});
        if (e.at >= 0) chk("event_cycle", cyc, e.at);
      end
    end
  end

  // kind: 0 no event, 1 FERR expected, 2 VALID expected (outputs = held).
  task automatic pulse(input logic [3:0] m, input logic [3:0] qv, input int kind,
                       output int n);
    exp_t e;
    @(negedge CP15);
    Q = qv;
    {DS4, DS3, DS2, DS1} = m;
    n = cyc + 1;               // posedge at which the strobe is first sampled
    if (kind != 0) begin
      e.is_valid = (kind == 2);
      e.at       = n + SS;
      e.outs     = held;
      sb.push_back(e);
    end
    repeat (3) @(negedge CP15);
    {DS4, DS3, DS2, DS1} = 4'd0;
    repeat (2) @(negedge CP15);
  endtask

  task automatic frame(input logic [3:0] q1, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] c,
                       input logic [26:0] want);
    int n;
    pulse(4'b0001, q1, 0, n);
    pulse(4'b0010, a, 0, n);
    pulse(4'b0100, b, 0, n);
    held = want;
    pulse(4'b1000, c, 2, n);
  endtask

  initial begin
    int   n;
    exp_t e;
    logic [26:0] f1234;
    f1234 = mk(1'b1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b0, 1'b0, 11'd1234);

    repeat (3) @(negedge CP15);
    chk("reset_outputs", {5'd0, cur()}, 32'd0);
    chk("reset_pulses", {30'd0, VALID, FERR}, 32'd0);
    R = 1'b1;

    frame(4'b0100, 4'd2, 4'd3, 4'd4, f1234);

    // DS2 skipped
    pulse(4'b0001, 4'b0100, 0, n);
    pulse(4'b0100, 4'd3, 1, n);
    frame(4'b0100, 4'd2, 4'd3, 4'd4, f1234);

    // non-BCD hundreds digit
    pulse(4'b0001, 4'b0100, 0, n);
    pulse(4'b0010, 4'hA, 1, n);
    frame(4'b0100, 4'd2, 4'd3, 4'd4, f1234);

    // DS2 and DS3 together
    pulse(4'b0001, 4'b0100, 0, n);
    pulse(4'b0110, 4'd2, 1, n);
    frame(4'b0100, 4'd2, 4'd3, 4'd4, f1234);

    frame(4'b1001, 4'd9, 4'd9, 4'd9,
          mk(1'b0, 4'd9, 4'd9, 4'd9, 1'b0, 1'b0, 1'b1, 11'd999));
    frame(4'b0101, 4'd0, 4'd0, 4'd0,
          mk(1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 11'd1000));

    // timeout: DS1 edge accepted at posedge n+SS, FERR TM-1 edges later
    pulse(4'b0001, 4'b0100, 0, n);
    e.is_valid = 1'b0;
    e.at       = n + SS + TM - 1;
    e.outs     = held;
    sb.push_back(e);
    repeat (20) @(negedge CP15);
    frame(4'b0100, 4'd8, 4'd8, 4'd8,
          mk(1'b1, 4'd8, 4'd8, 4'd8, 1'b1, 1'b0, 1'b0, 11'd1888));

    // joined mid-frame: DS3, DS4 alone are ignored
    pulse(4'b0100, 4'd3, 0, n);
    pulse(4'b1000, 4'd4, 0, n);
    frame(4'b0100, 4'd5, 4'd6, 4'd7,
          mk(1'b1, 4'd5, 4'd6, 4'd7, 1'b1, 1'b0, 1'b0, 11'd1567));

    // reset between DS2 and DS3
    pulse(4'b0001, 4'b1000, 0, n);
    pulse(4'b0010, 4'd1, 0, n);
    @(negedge CP15);
    R = 1'b0;
    @(negedge CP15);
    R = 1'b1;
    chk("midframe_reset_outputs", {5'd0, cur()}, 32'd0);
    held = '0;
    pulse(4'b0100, 4'd2, 0, n);
    pulse(4'b1000, 4'd3, 0, n);
    frame(4'b1000, 4'd4, 4'd5, 4'd6,
          mk(1'b0, 4'd4, 4'd5, 4'd6, 1'b0, 1'b0, 1'b0, 11'd456));

    repeat (10) @(negedge CP15);
    chk("queue_drained", sb.size(), 32'd0);
    chk("final_hold", {5'd0, cur()}, {5'd0, held});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc14433_bcd_rx.md
Name: mc14433_bcd_rx

Overview:
- Receiving end of the MC14433 multiplexed BCD output interface.
- Monitors digit strobes DS1..DS4 and the shared data lines Q[3:0], clocked by CP15.
- Reassembles one complete 3½-digit conversion frame: half digit, three BCD digits, polarity and over/under-range flags.
- Publishes the frame as latched BCD plus an 11-bit binary magnitude, and flags malformed frames.
- Sits between the MC14433 model and display or host logic.

Parameters:
- SYNC_STAGES, 2: input synchroniser depth applied equally to DS1..DS4 and Q[3:0]. Legal range 1..3.
- TMO, 4096: maximum CP15 cycles allowed between consecutive strobe edges inside a frame. Must be ≥ 2.

Ports:
- CP15 input 1: clock, rising edge.
- R input 1: reset, synchronous, active-low.
- DS1 input 1: digit strobe, MSD (half digit, polarity, range), active-high.
- DS2 input 1: digit strobe, hundreds digit.
- DS3 input 1: digit strobe, tens digit.
- DS4 input 1: digit strobe, units digit (LSD).
- Q input 4: multiplexed data, valid while the selected strobe is high.
- MSD output 1: half digit (0 or 1).
- D2 output 4: hundreds BCD.
- D3 output 4: tens BCD.
- D4 output 4: units BCD.
- POL output 1: polarity, 1 = positive.
- OVR output 1: overrange.
- UNR output 1: underrange.
- BIN output 11: MSD*1000 + D2*100 + D3*10 + D4, range 0..1999.
- VALID output 1: one-cycle pulse when outputs update.
- FERR output 1: one-cycle frame-error pulse.

Behaviour:
- Reset: R sampled low at a CP15 edge clears all outputs, synchronisers, shadow registers, timeout counter and FSM to IDLE. R low mid-frame discards the partial frame and asserts no FERR.
- Synchronisers:
  - DS1..DS4 and Q each pass through SYNC_STAGES flops.
  - One extra flop on each synced strobe gives the previous value for rising-edge detection. An edge = synced high and previous low.
  - Q is captured from the last sync stage in the edge cycle.
- DS1 decode:
  - MSD = ~Q[3].
  - POL = Q[2].
  - Q[0]=1 with Q[3]=0 means overrange.
  - Q[0]=1 with Q[3]=1 means underrange.
  - Q[1] is ignored.
- FSM states: IDLE, WAIT2, WAIT3, WAIT4.
  - IDLE: DS1 edge stores the DS1 fields in shadow registers and goes to WAIT2. Other strobe edges are ignored; this is mid-frame start-up and raises no FERR.
  - WAITk, expected DSk edge: capture Q into shadow digit k and advance. From WAIT4, a DS4 edge completes the frame.
  - WAITk, DS1 edge: FERR pulse, then treat the edge as a new frame start (store DS1 fields, go to WAIT2).
  - WAITk, any other single unexpected edge: FERR pulse, go to IDLE.
  - More than one strobe edge in the same cycle, any state: FERR pulse, go to IDLE. This applies in IDLE too if DS1 is among the edges.
  - Captured digit > 9 on DS2/DS3/DS4: FERR pulse, go to IDLE, no output update.
- Timeout counter:
  - Cleared on every accepted edge; counts every cycle in WAIT2..WAIT4.
  - On reaching TMO-1 with no accepted edge: FERR pulse, go to IDLE.
  - An accepted edge in the same cycle as the timeout wins.
- Frame completion:
  - At the edge after a valid DS4 edge cycle, MSD/D2/D3/D4/POL/OVR/UNR/BIN update together and VALID is high for exactly that one cycle. FSM returns to IDLE.
  - BIN is computed from the shadow registers plus the incoming D4, so it updates in the same cycle as the BCD outputs.
- Latency: if DS4 is first sampled high at CP15 edge n, outputs and VALID assert at edge n+SYNC_STAGES.
- Hold: outputs hold the last valid frame indefinitely; an errored frame never changes them.
- Input timing:
  - Strobes must be high ≥1 CP15 cycle.
  - Q must be stable while its strobe is high.
  - A strobe held high across cycles yields one edge only.
- VALID and FERR are never high in the same cycle.

Test Plan:
- Reset, then frame DS1 Q=0b0100, DS2 Q=2, DS3 Q=3, DS4 Q=4 (each strobe 3 cycles, 2-cycle gaps) -> MSD=1, D2=2, D3=3, D4=4, POL=1, OVR=0, UNR=0, BIN=1234; one VALID pulse at DS4 sample edge +2; FERR never high.
- DS1 Q=0b1001, then 9,9,9 -> MSD=0, POL=0, UNR=1, OVR=0, BIN=999. Next frame DS1 Q=0b0101, then 0,0,0 -> OVR=1, UNR=0, POL=1, BIN=1000.
- Error cases, each followed by a clean frame that must still produce VALID:
  - DS1 then DS3 (DS2 skipped) -> one FERR, outputs keep 1234, FSM idle.
  - DS1, DS2 with Q=0xA -> one FERR, outputs keep 1234.
  - DS2 and DS3 rising together -> one FERR.
- Timeout, TMO=16: DS1 edge, then no strobe for 20 cycles -> FERR exactly 15 cycles after the DS1 edge cycle; a subsequent full frame 1,8,8,8 -> BIN=1888.
- Start mid-frame (first edges DS3, DS4) -> no VALID, no FERR; the following full frame is accepted normally.
- Assert R low for one cycle between DS2 and DS3 of a frame -> all outputs 0, no FERR; the remaining DS3/DS4 edges are ignored; the next full frame updates normally.
